// File: rtl/dlsc_pxdma_pkg.sv
// Shared definitions for the pxdma AXI write arbiter.
//   AXI_RESP_OKAY / AXI_RESP_SLVERR : AXI B response encodings
//   pb_width()                      : port index width for a given port count
package dlsc_pxdma_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   // Never returns 0 so that index vectors stay legal for degenerate counts.
   function automatic int unsigned pb_width(input int unsigned ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/dlsc_pxdma_arb_order.sv
// Synchronous index FIFO that records AW grant order.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   push_i/_data_i  : enqueue request and port index
//   pop_i           : dequeue request
//   head_o          : oldest entry (valid while !empty_o)
//   empty_o, full_o : occupancy flags
// A push is refused while full even if a pop happens in the same cycle.
module dlsc_pxdma_arb_order
   import dlsc_pxdma_pkg::*;
#(
   parameter int unsigned DATA  = 1,
   parameter int unsigned DEPTH = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            push_i,
   input  logic [DATA-1:0] push_data_i,
   input  logic            pop_i,
   output logic [DATA-1:0] head_o,
   output logic            empty_o,
   output logic            full_o
);

   localparam int unsigned AB = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA-1:0] mem_q [DEPTH];
   logic [AB-1:0]   wr_q, wr_d;
   logic [AB-1:0]   rd_q, rd_d;
   logic [AB:0]     cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (AB+1)'(DEPTH));
   assign head_o  = mem_q[rd_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         wr_d = (wr_q == AB'(DEPTH-1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) begin
         rd_d = (rd_q == AB'(DEPTH-1)) ? '0 : rd_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by cnt_q.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/dlsc_pxdma_axi_wr_arbiter.sv
// Shares one AXI write master among PORTS pxdma writers.
// AW is arbitrated (round-robin by default) into a registered slot; grant order
// is recorded in W and B order FIFOs that steer W bursts and B responses.
// Outstanding writes are capped at MOT (B FIFO occupancy).
//   clk_i, rst_i       : clock, synchronous active-high reset
//   in_aw_* / in_w_* / in_b_* : per-port packed upstream channels
//   axi_aw_* / axi_w_* / axi_b_* : shared downstream channels
//   error_o            : sticky, B arrived with no outstanding transaction
// Build option: DLSC_PXDMA_ARB_PRIORITY_EN selects fixed priority (lowest port wins).
module dlsc_pxdma_axi_wr_arbiter
   import dlsc_pxdma_pkg::*;
#(
   parameter int unsigned PORTS = 2,
   parameter int unsigned ADDR  = 32,
   parameter int unsigned LEN   = 4,
   parameter int unsigned MOT   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic [PORTS-1:0]      in_aw_ready_o,
   input  logic [PORTS-1:0]      in_aw_valid_i,
   input  logic [PORTS*ADDR-1:0] in_aw_addr_i,
   input  logic [PORTS*LEN-1:0]  in_aw_len_i,
   output logic [PORTS-1:0]      in_w_ready_o,
   input  logic [PORTS-1:0]      in_w_valid_i,
   input  logic [PORTS-1:0]      in_w_last_i,
   input  logic [PORTS*32-1:0]   in_w_data_i,
   input  logic [PORTS*4-1:0]    in_w_strb_i,
   input  logic [PORTS-1:0]      in_b_ready_i,
   output logic [PORTS-1:0]      in_b_valid_o,
   output logic [PORTS*2-1:0]    in_b_resp_o,
   input  logic                  axi_aw_ready_i,
   output logic                  axi_aw_valid_o,
   output logic [ADDR-1:0]       axi_aw_addr_o,
   output logic [LEN-1:0]        axi_aw_len_o,
   input  logic                  axi_w_ready_i,
   output logic                  axi_w_valid_o,
   output logic                  axi_w_last_o,
   output logic [31:0]           axi_w_data_o,
   output logic [3:0]            axi_w_strb_o,
   output logic                  axi_b_ready_o,
   input  logic                  axi_b_valid_i,
   input  logic [1:0]            axi_b_resp_i,
   output logic                  error_o
);

   localparam int unsigned PB = pb_width(PORTS);

   logic            aw_valid_q, aw_valid_d;
   logic [ADDR-1:0] aw_addr_q, aw_addr_d;
   logic [LEN-1:0]  aw_len_q, aw_len_d;
   logic            error_q, error_d;

   logic [PB-1:0]   win;
   logic            any_req;
   logic            can_grant;
   logic            grant;

   logic [PB-1:0]   w_head, b_head;
   logic            w_empty, w_full, w_pop;
   logic            b_empty, b_full, b_pop;

`ifndef DLSC_PXDMA_ARB_PRIORITY_EN
   logic [PB-1:0]   rr_q, rr_d;
   int unsigned     idx;
`endif

   // ---------------------------------------------------------------- arbitration
   // Loops run from lowest to highest priority so the last match wins.
   always_comb begin
      win     = '0;
      any_req = 1'b0;
`ifdef DLSC_PXDMA_ARB_PRIORITY_EN
      for (int i = int'(PORTS) - 1; i >= 0; i--) begin
         if (in_aw_valid_i[i]) begin
            win     = PB'(i);
            any_req = 1'b1;
         end
      end
`else
      idx = 0;
      for (int i = int'(PORTS); i >= 1; i--) begin
         idx = (int'(rr_q) + i) % int'(PORTS);
         if (in_aw_valid_i[idx]) begin
            win     = PB'(idx);
            any_req = 1'b1;
         end
      end
`endif
   end

   assign can_grant = (!aw_valid_q || axi_aw_ready_i) && !w_full && !b_full;
   assign grant     = can_grant && any_req;

   always_comb begin
      in_aw_ready_o = '0;
      if (grant) begin
         in_aw_ready_o[win] = 1'b1;
      end
   end

   // ---------------------------------------------------------------- AW slot
   always_comb begin
      aw_valid_d = aw_valid_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      if (grant) begin
         aw_valid_d = 1'b1;
         aw_addr_d  = in_aw_addr_i[int'(win)*ADDR +: ADDR];
         aw_len_d   = in_aw_len_i[int'(win)*LEN +: LEN];
      end else if (axi_aw_ready_i) begin
         aw_valid_d = 1'b0;
      end
   end

`ifndef DLSC_PXDMA_ARB_PRIORITY_EN
   assign rr_d = grant ? win : rr_q;
`endif

   assign axi_aw_valid_o = aw_valid_q;
   assign axi_aw_addr_o  = aw_addr_q;
   assign axi_aw_len_o   = aw_len_q;

   // ---------------------------------------------------------------- W steering
   always_comb begin
      in_w_ready_o  = '0;
      axi_w_valid_o = 1'b0;
      axi_w_last_o  = 1'b0;
      axi_w_data_o  = '0;
      axi_w_strb_o  = '0;
      if (!w_empty) begin
         in_w_ready_o[w_head] = axi_w_ready_i;
         axi_w_valid_o        = in_w_valid_i[w_head];
         axi_w_last_o         = in_w_last_i[w_head];
         axi_w_data_o         = in_w_data_i[int'(w_head)*32 +: 32];
         axi_w_strb_o         = in_w_strb_i[int'(w_head)*4 +: 4];
      end
   end

   assign w_pop = axi_w_valid_o && axi_w_ready_i && axi_w_last_o;

   // ---------------------------------------------------------------- B steering
   always_comb begin
      in_b_valid_o  = '0;
      in_b_resp_o   = '0;
      axi_b_ready_o = 1'b0;
      if (!b_empty) begin
         in_b_valid_o[b_head]               = axi_b_valid_i;
         in_b_resp_o[int'(b_head)*2 +: 2]   = axi_b_resp_i;
         axi_b_ready_o                      = in_b_ready_i[b_head];
      end else begin
         // Unexpected response: drain it so the interconnect never stalls.
         axi_b_ready_o = axi_b_valid_i;
      end
   end

   assign b_pop   = !b_empty && axi_b_valid_i && in_b_ready_i[b_head];
   assign error_d = error_q || (b_empty && axi_b_valid_i);
   assign error_o = error_q;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         error_q    <= 1'b0;
`ifndef DLSC_PXDMA_ARB_PRIORITY_EN
         rr_q       <= PB'(PORTS - 1);
`endif
      end else begin
         aw_valid_q <= aw_valid_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         error_q    <= error_d;
`ifndef DLSC_PXDMA_ARB_PRIORITY_EN
         rr_q       <= rr_d;
`endif
      end
   end

   // ---------------------------------------------------------------- order FIFOs
   dlsc_pxdma_arb_order #(
      .DATA  (PB),
      .DEPTH (MOT)
   ) u_w_order (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (grant),
      .push_data_i (win),
      .pop_i       (w_pop),
      .head_o      (w_head),
      .empty_o     (w_empty),
      .full_o      (w_full)
   );

   dlsc_pxdma_arb_order #(
      .DATA  (PB),
      .DEPTH (MOT)
   ) u_b_order (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (grant),
      .push_data_i (win),
      .pop_i       (b_pop),
      .head_o      (b_head),
      .empty_o     (b_empty),
      .full_o      (b_full)
   );

endmodule

// File: tb/tb_dlsc_pxdma_axi_wr_arbiter.sv
// Directed bench for dlsc_pxdma_axi_wr_arbiter with PORTS = 2, MOT = 4.
module tb_dlsc_pxdma_axi_wr_arbiter;
   import dlsc_pxdma_pkg::*;

   localparam int unsigned PORTS = 2;
   localparam int unsigned ADDR  = 32;
   localparam int unsigned LEN   = 4;
   localparam int unsigned MOT   = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [PORTS-1:0]      in_aw_ready;
   logic [PORTS-1:0]      in_aw_valid;
   logic [PORTS*ADDR-1:0] in_aw_addr;
   logic [PORTS*LEN-1:0]  in_aw_len;
   logic [PORTS-1:0]      in_w_ready;
   logic [PORTS-1:0]      in_w_valid;
   logic [PORTS-1:0]      in_w_last;
   logic [PORTS*32-1:0]   in_w_data;
   logic [PORTS*4-1:0]    in_w_strb;
   logic [PORTS-1:0]      in_b_ready;
   logic [PORTS-1:0]      in_b_valid;
   logic [PORTS*2-1:0]    in_b_resp;
   logic                  axi_aw_ready;
   logic                  axi_aw_valid;
   logic [ADDR-1:0]       axi_aw_addr;
   logic [LEN-1:0]        axi_aw_len;
   logic                  axi_w_ready;
   logic                  axi_w_valid;
   logic                  axi_w_last;
   logic [31:0]           axi_w_data;
   logic [3:0]            axi_w_strb;
   logic                  axi_b_ready;
   logic                  axi_b_valid;
   logic [1:0]            axi_b_resp;
   logic                  error;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dlsc_pxdma_axi_wr_arbiter #(
      .PORTS (PORTS),
      .ADDR  (ADDR),
      .LEN   (LEN),
      .MOT   (MOT)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .in_aw_ready_o  (in_aw_ready),
      .in_aw_valid_i  (in_aw_valid),
      .in_aw_addr_i   (in_aw_addr),
      .in_aw_len_i    (in_aw_len),
      .in_w_ready_o   (in_w_ready),
      .in_w_valid_i   (in_w_valid),
      .in_w_last_i    (in_w_last),
      .in_w_data_i    (in_w_data),
      .in_w_strb_i    (in_w_strb),
      .in_b_ready_i   (in_b_ready),
      .in_b_valid_o   (in_b_valid),
      .in_b_resp_o    (in_b_resp),
      .axi_aw_ready_i (axi_aw_ready),
      .axi_aw_valid_o (axi_aw_valid),
      .axi_aw_addr_o  (axi_aw_addr),
      .axi_aw_len_o   (axi_aw_len),
      .axi_w_ready_i  (axi_w_ready),
      .axi_w_valid_o  (axi_w_valid),
      .axi_w_last_o   (axi_w_last),
      .axi_w_data_o   (axi_w_data),
      .axi_w_strb_o   (axi_w_strb),
      .axi_b_ready_o  (axi_b_ready),
      .axi_b_valid_i  (axi_b_valid),
      .axi_b_resp_i   (axi_b_resp),
      .error_o        (error)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      in_aw_valid  = '0;
      in_aw_addr   = '0;
      in_aw_len    = '0;
      in_w_valid   = '0;
      in_w_last    = '0;
      in_w_data    = '0;
      in_w_strb    = '0;
      in_b_ready   = '0;
      axi_aw_ready = 1'b0;
      axi_w_ready  = 1'b0;
      axi_b_valid  = 1'b0;
      axi_b_resp   = AXI_RESP_OKAY;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_aw_valid", 64'(axi_aw_valid), 64'd0);
      chk("rst_w_valid", 64'(axi_w_valid), 64'd0);
      chk("rst_b_ready", 64'(axi_b_ready), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_in_aw_ready", 64'(in_aw_ready), 64'd0);
      chk("rst_in_w_ready", 64'(in_w_ready), 64'd0);
      chk("rst_in_b_valid", 64'(in_b_valid), 64'd0);

      // Round-robin with both ports requesting; MOT=4 stops after 4 grants.
      in_aw_addr   = {32'h0000_2000, 32'h0000_1000};
      in_aw_len    = '0;
      in_aw_valid  = 2'b11;
      axi_aw_ready = 1'b1;
      #1;
      chk("rr_first_p0", 64'(in_aw_ready), 64'b01);
      tick();
      chk("rr_aw_valid", 64'(axi_aw_valid), 64'd1);
      chk("rr_addr0", 64'(axi_aw_addr), 64'h1000);
      chk("rr_next_p1", 64'(in_aw_ready), 64'b10);
      tick();
      chk("rr_addr1", 64'(axi_aw_addr), 64'h2000);
      chk("rr_next_p0", 64'(in_aw_ready), 64'b01);
      tick();
      chk("rr_addr2", 64'(axi_aw_addr), 64'h1000);
      chk("rr_next_p1b", 64'(in_aw_ready), 64'b10);
      tick();
      chk("rr_addr3", 64'(axi_aw_addr), 64'h2000);
      chk("mot_block", 64'(in_aw_ready), 64'b00);
      in_aw_valid = 2'b00;
      tick();
      chk("aw_slot_drained", 64'(axi_aw_valid), 64'd0);

      // Drain four single-beat W bursts in grant order 0,1,0,1.
      in_w_data   = {32'h0000_00B1, 32'h0000_00A0};
      in_w_strb   = {4'h3, 4'hF};
      in_w_valid  = 2'b11;
      in_w_last   = 2'b11;
      axi_w_ready = 1'b1;
      #1;
      chk("w0_valid", 64'(axi_w_valid), 64'd1);
      chk("w0_data", 64'(axi_w_data), 64'hA0);
      chk("w0_strb", 64'(axi_w_strb), 64'hF);
      chk("w0_ready", 64'(in_w_ready), 64'b01);
      tick();
      chk("w1_data", 64'(axi_w_data), 64'hB1);
      chk("w1_strb", 64'(axi_w_strb), 64'h3);
      chk("w1_ready", 64'(in_w_ready), 64'b10);
      tick();
      tick();
      tick();
      in_aw_valid = 2'b11;
      #1;
      chk("w_empty_valid", 64'(axi_w_valid), 64'd0);
      chk("w_empty_ready", 64'(in_w_ready), 64'b00);
      chk("mot_block_b_full", 64'(in_aw_ready), 64'b00);
      in_aw_valid = 2'b00;
      in_w_valid  = 2'b00;

      // First B goes to port 0 with SLVERR, freeing exactly one slot.
      axi_b_valid = 1'b1;
      axi_b_resp  = AXI_RESP_SLVERR;
      in_b_ready  = 2'b11;
      #1;
      chk("b0_valid", 64'(in_b_valid), 64'b01);
      chk("b0_resp", 64'(in_b_resp), 64'b0010);
      chk("b0_ready", 64'(axi_b_ready), 64'd1);
      tick();
      axi_b_valid = 1'b0;
      in_aw_addr  = {32'h0000_2000, 32'h0000_5000};
      in_aw_valid = 2'b11;
      #1;
      chk("mot_reopen", 64'(in_aw_ready), 64'b01);
      tick();
      chk("mot_regrant_addr", 64'(axi_aw_addr), 64'h5000);
      chk("mot_one_only", 64'(in_aw_ready), 64'b00);
      in_aw_valid = 2'b00;

      // B order is now 1,0,1,0; stall port 1 first.
      axi_b_valid = 1'b1;
      axi_b_resp  = AXI_RESP_SLVERR;
      in_b_ready  = 2'b01;
      #1;
      chk("b_stall_valid", 64'(in_b_valid), 64'b10);
      chk("b_stall_ready", 64'(axi_b_ready), 64'd0);
      chk("b_stall_resp", 64'(in_b_resp), 64'b1000);
      tick();
      chk("b_stall_hold", 64'(in_b_valid), 64'b10);
      in_b_ready = 2'b11;
      axi_b_resp = AXI_RESP_OKAY;
      #1;
      chk("b1_ready", 64'(axi_b_ready), 64'd1);
      chk("b1_resp", 64'(in_b_resp), 64'b0000);
      tick();
      chk("b2_valid", 64'(in_b_valid), 64'b01);
      tick();
      chk("b3_valid", 64'(in_b_valid), 64'b10);
      tick();
      chk("b4_valid", 64'(in_b_valid), 64'b01);
      tick();
      // No outstanding transactions left: spurious response.
      chk("spur_drain", 64'(axi_b_ready), 64'd1);
      chk("spur_no_valid", 64'(in_b_valid), 64'b00);
      chk("spur_err_pre", 64'(error), 64'd0);
      tick();
      chk("spur_err_set", 64'(error), 64'd1);
      axi_b_valid = 1'b0;
      tick();
      chk("spur_err_sticky", 64'(error), 64'd1);
      chk("spur_idle_ready", 64'(axi_b_ready), 64'd0);

      // Retire the single-beat W from the regrant to port 0.
      in_w_valid = 2'b01;
      in_w_last  = 2'b01;
      #1;
      chk("wr_valid", 64'(axi_w_valid), 64'd1);
      tick();
      in_w_valid = 2'b11;
      #1;
      chk("wr_empty", 64'(axi_w_valid), 64'd0);
      in_w_valid = 2'b00;
      in_w_last  = 2'b00;

      // W steering: port 1 len=3, then port 0 len=0.
      in_aw_addr  = {32'h0000_3000, 32'h0000_4000};
      in_aw_len   = {4'd3, 4'd0};
      in_aw_valid = 2'b10;
      #1;
      chk("ws_grant_p1", 64'(in_aw_ready), 64'b10);
      tick();
      in_aw_valid = 2'b01;
      #1;
      chk("ws_grant_p0", 64'(in_aw_ready), 64'b01);
      chk("ws_len_p1", 64'(axi_aw_len), 64'd3);
      chk("ws_addr_p1", 64'(axi_aw_addr), 64'h3000);
      tick();
      in_aw_valid = 2'b00;
      #1;
      chk("ws_addr_p0", 64'(axi_aw_addr), 64'h4000);
      chk("ws_len_p0", 64'(axi_aw_len), 64'd0);
      in_w_data  = {32'h0000_00D0, 32'h0000_00C0};
      in_w_valid = 2'b11;
      in_w_last  = 2'b00;
      #1;
      chk("ws_b0_data", 64'(axi_w_data), 64'hD0);
      chk("ws_b0_ready", 64'(in_w_ready), 64'b10);
      chk("ws_b0_last", 64'(axi_w_last), 64'd0);
      axi_w_ready = 1'b0;
      #1;
      chk("ws_stall_ready", 64'(in_w_ready), 64'b00);
      chk("ws_stall_valid", 64'(axi_w_valid), 64'd1);
      tick();
      axi_w_ready = 1'b1;
      tick();
      in_w_data = {32'h0000_00D1, 32'h0000_00C0};
      tick();
      in_w_data = {32'h0000_00D2, 32'h0000_00C0};
      tick();
      in_w_data = {32'h0000_00D3, 32'h0000_00C0};
      in_w_last = 2'b10;
      #1;
      chk("ws_b3_last", 64'(axi_w_last), 64'd1);
      chk("ws_b3_data", 64'(axi_w_data), 64'hD3);
      chk("ws_b3_ready", 64'(in_w_ready), 64'b10);
      tick();
      in_w_last = 2'b01;
      #1;
      chk("ws_p0_data", 64'(axi_w_data), 64'hC0);
      chk("ws_p0_ready", 64'(in_w_ready), 64'b01);
      chk("ws_p0_last", 64'(axi_w_last), 64'd1);
      tick();
      chk("ws_done", 64'(axi_w_valid), 64'd0);
      in_w_valid = 2'b00;
      in_w_last  = 2'b00;

      // Reset in the middle of a burst with the AW slot still held.
      axi_aw_ready = 1'b0;
      in_aw_valid  = 2'b10;
      tick();
      in_aw_valid = 2'b00;
      in_w_data   = {32'h0000_00E4, 32'h0000_00C0};
      in_w_valid  = 2'b10;
      #1;
      chk("mr_aw_held", 64'(axi_aw_valid), 64'd1);
      chk("mr_w_valid", 64'(axi_w_valid), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      chk("mr_aw_valid", 64'(axi_aw_valid), 64'd0);
      chk("mr_w_valid_clr", 64'(axi_w_valid), 64'd0);
      chk("mr_error", 64'(error), 64'd0);
      rst          = 1'b0;
      axi_aw_ready = 1'b1;
      in_w_valid   = 2'b00;
      in_aw_valid  = 2'b11;
      #1;
      chk("mr_first_p0", 64'(in_aw_ready), 64'b01);
      tick();
      chk("mr_addr_p0", 64'(axi_aw_addr), 64'h4000);
      chk("mr_aw_valid_set", 64'(axi_aw_valid), 64'd1);
      in_aw_valid = 2'b00;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
